// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM-stage controller; maps loads/stores onto a req/ack word bus and registers MEM/WB.
// Latency: 1 cycle for non-memory ops, ack latency + 2 cycles for loads/stores (3 minimum).
// Backpressure: freeze holds the upstream pipeline from access detect until the bus ack or timeout.
//
// Ports: clk/rstn (sync, active-low); EX/MEM inputs wb_en_in, mem_r_en_in, mem_w_en_in,
// alu_res_in, st_val_in, dest_in; bus side bus_req/bus_we/bus_addr/bus_wdata out and
// bus_ack/bus_rdata in; MEM/WB outputs wb_en_out, mem_r_en_out, alu_res_out, mem_data_out,
// dest_out; freeze to the upstream stages; mem_err one-cycle error pulse.
module mem_stage_ctrl #(
    parameter int WORD_LEN          = 32,
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int BUS_ADDR_LEN      = 8,
    parameter int DATA_BASE         = 1024,
    parameter int TIMEOUT_CYC       = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wb_en_in,
    input  logic                         mem_r_en_in,
    input  logic                         mem_w_en_in,
    input  logic [WORD_LEN-1:0]          alu_res_in,
    input  logic [WORD_LEN-1:0]          st_val_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
    output logic                         freeze,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [BUS_ADDR_LEN-1:0]      bus_addr,
    output logic [WORD_LEN-1:0]          bus_wdata,
    input  logic                         bus_ack,
    input  logic [WORD_LEN-1:0]          bus_rdata,
    output logic                         wb_en_out,
    output logic                         mem_r_en_out,
    output logic [WORD_LEN-1:0]          alu_res_out,
    output logic [WORD_LEN-1:0]          mem_data_out,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
    output logic                         mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WORD_LEN-1:0] BASE_W = WORD_LEN'(DATA_BASE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]             cnt;
    logic                         access;
    logic                         addr_ok;
    logic                         timeout_hit;
    logic [WORD_LEN-1:0]          offs;

    // Transaction latches, captured on the detect cycle
    logic [BUS_ADDR_LEN-1:0]      lat_idx;
    logic [WORD_LEN-1:0]          lat_wdata;
    logic                         lat_we;
    logic                         lat_wb_en;
    logic                         lat_r_en;
    logic [REG_FILE_ADDR_LEN-1:0] lat_dest;
    logic [WORD_LEN-1:0]          lat_alu;
    logic [WORD_LEN-1:0]          lat_data;
    logic                         lat_err;

    assign access = mem_r_en_in | mem_w_en_in;
    assign offs   = alu_res_in - BASE_W;

    // Word index fits the bus only if every offset bit above the index field is zero;
    // the >= test keeps a wrapped (negative) offset from looking in range.
    assign addr_ok = (alu_res_in[1:0] == 2'b00)
                   && (alu_res_in >= BASE_W)
                   && (offs[WORD_LEN-1:BUS_ADDR_LEN+2] == '0)
                   && !(mem_r_en_in && mem_w_en_in);

    // cnt holds REQ cycles already spent, so this is the TIMEOUT_CYC-th REQ cycle
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    assign bus_addr  = lat_idx;
    assign bus_we    = lat_we;
    assign bus_wdata = lat_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (access && addr_ok) state_nxt = ST_REQ;
            ST_REQ:  if (bus_ack || timeout_hit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; DONE releases freeze while the stale instruction is still presented
    always_comb begin
        freeze  = 1'b0;
        bus_req = 1'b0;
        case (state)
            ST_IDLE: freeze = access && addr_ok;
            ST_REQ: begin
                freeze  = 1'b1;
                bus_req = 1'b1;
            end
            default: begin
                freeze  = 1'b0;
                bus_req = 1'b0;
            end
        endcase
    end

    // Datapath: transaction latches, timeout counter and MEM/WB register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt          <= '0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            lat_we       <= 1'b0;
            lat_wb_en    <= 1'b0;
            lat_r_en     <= 1'b0;
            lat_dest     <= '0;
            lat_alu      <= '0;
            lat_data     <= '0;
            lat_err      <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= '0;
            mem_data_out <= '0;
            dest_out     <= '0;
            mem_err      <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    alu_res_out  <= alu_res_in;
                    dest_out     <= dest_in;
                    mem_r_en_out <= 1'b0;
                    if (access) begin
                        // Bubble into MEM/WB for both the error and the bus path
                        wb_en_out <= 1'b0;
                        mem_err   <= !addr_ok;
                        if (addr_ok) begin
                            lat_idx   <= offs[BUS_ADDR_LEN+1:2];
                            lat_wdata <= st_val_in;
                            lat_we    <= mem_w_en_in;
                            lat_wb_en <= wb_en_in;
                            lat_r_en  <= mem_r_en_in;
                            lat_dest  <= dest_in;
                            lat_alu   <= alu_res_in;
                            lat_err   <= 1'b0;
                            cnt       <= '0;
                        end
                    end else begin
                        wb_en_out <= wb_en_in;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a coincident timeout
                    if (bus_ack) begin
                        if (lat_r_en) lat_data <= bus_rdata;
                    end else if (timeout_hit) begin
                        lat_err  <= 1'b1;
                        lat_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    cnt          <= '0;
                    alu_res_out  <= lat_alu;
                    dest_out     <= lat_dest;
                    mem_data_out <= lat_data;
                    wb_en_out    <= lat_wb_en && !lat_err;
                    mem_r_en_out <= lat_r_en && !lat_err;
                    mem_err      <= lat_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose: self-checking bench for mem_stage_ctrl against a transaction-level reference model.
// Latency: each instruction is followed through to its MEM/WB result before the next is issued.
// Backpressure: the bench plays the upstream pipeline, holding inputs while freeze is high.
module tb_mem_stage_ctrl;

    localparam int WL   = 32;
    localparam int RL   = 5;
    localparam int BL   = 8;
    localparam int BASE = 1024;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [WL-1:0] alu_res_in, st_val_in;
    logic [RL-1:0] dest_in;
    logic          freeze, bus_req, bus_we;
    logic [BL-1:0] bus_addr;
    logic [WL-1:0] bus_wdata;
    logic          bus_ack;
    logic [WL-1:0] bus_rdata;
    logic          wb_en_out, mem_r_en_out;
    logic [WL-1:0] alu_res_out, mem_data_out;
    logic [RL-1:0] dest_out;
    logic          mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the word the controller will hand to MEM/WB at its next completed access
    logic [WL-1:0] data_latch;
    logic [WL-1:0] exp_md;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .WORD_LEN(WL), .REG_FILE_ADDR_LEN(RL), .BUS_ADDR_LEN(BL),
        .DATA_BASE(BASE), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .freeze(freeze), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
        .dest_out(dest_out), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Address rule written with plain integer arithmetic
    function automatic bit addr_valid(input logic [31:0] a, input logic r, input logic w);
        longint unsigned av;
        av = longint'(a);
        return (av % 4 == 0) && (av >= BASE) && ((av - BASE) / 4 < (1 << BL)) && !(r && w);
    endfunction

    task automatic drive_idle();
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        alu_res_in = '0; st_val_in = '0; dest_in = '0;
    endtask

    // Present one instruction (caller is at posedge+1) and follow it to its MEM/WB result.
    // ack_at: REQ cycle index (0-based) in which the bus acks; negative means never.
    task automatic run_instr(input logic wb, input logic r, input logic w,
                             input logic [31:0] alu, input logic [31:0] st,
                             input logic [4:0] dest, input int ack_at,
                             input logic [31:0] rd, input bit stray_ack);
        bit acc, ok, timed_out;
        logic [31:0] idx;
        acc = r || w;
        ok  = acc && addr_valid(alu, r, w);
        idx = (alu - BASE) / 4;
        wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
        alu_res_in = alu; st_val_in = st; dest_in = dest;
        #1;
        check("freeze_detect", 32'(freeze), 32'(ok));
        check("req_detect", 32'(bus_req), 32'd0);
        if (!acc) begin
            if (stray_ack) begin bus_ack = 1'b1; bus_rdata = $urandom; end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            check("alu_wb_en", 32'(wb_en_out), 32'(wb));
            check("alu_mr_en", 32'(mem_r_en_out), 32'd0);
            check("alu_res", alu_res_out, alu);
            check("alu_dest", 32'(dest_out), 32'(dest));
            check("alu_md_hold", mem_data_out, exp_md);
            check("alu_err", 32'(mem_err), 32'd0);
            check("alu_req", 32'(bus_req), 32'd0);
        end else if (!ok) begin
            @(posedge clk); #1;
            check("bad_err", 32'(mem_err), 32'd1);
            check("bad_wb_en", 32'(wb_en_out), 32'd0);
            check("bad_mr_en", 32'(mem_r_en_out), 32'd0);
            check("bad_req", 32'(bus_req), 32'd0);
            check("bad_md_hold", mem_data_out, exp_md);
        end else begin
            timed_out = 1'b1;
            @(posedge clk); #1;
            for (int n = 0; n < TO; n++) begin
                check("req_hi", 32'(bus_req), 32'd1);
                check("req_freeze", 32'(freeze), 32'd1);
                check("req_addr", 32'(bus_addr), idx);
                check("req_we", 32'(bus_we), 32'(w));
                if (w) check("req_wdata", bus_wdata, st);
                check("req_err", 32'(mem_err), 32'd0);
                check("req_bubble", 32'(wb_en_out), 32'd0);
                if (n == ack_at) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                    @(posedge clk); #1;
                    bus_ack = 1'b0; bus_rdata = $urandom;
                    timed_out = 1'b0;
                    if (r) data_latch = rd;
                    break;
                end
                bus_rdata = $urandom;
                @(posedge clk); #1;
            end
            if (timed_out) data_latch = '0;
            // DONE: stale instruction still on inputs, must not retrigger
            check("done_req", 32'(bus_req), 32'd0);
            check("done_freeze", 32'(freeze), 32'd0);
            @(posedge clk); #1;
            exp_md = data_latch;
            if (timed_out) begin
                check("to_err", 32'(mem_err), 32'd1);
                check("to_wb_en", 32'(wb_en_out), 32'd0);
                check("to_mr_en", 32'(mem_r_en_out), 32'd0);
            end else begin
                check("mem_err", 32'(mem_err), 32'd0);
                check("mem_wb_en", 32'(wb_en_out), 32'(wb));
                check("mem_mr_en", 32'(mem_r_en_out), 32'(r));
                check("mem_alu", alu_res_out, alu);
                check("mem_dest", 32'(dest_out), 32'(dest));
            end
            check("mem_data", mem_data_out, exp_md);
            check("wb_req", 32'(bus_req), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb_en"}, 32'(wb_en_out), 32'd0);
        check({tag, "_mr_en"}, 32'(mem_r_en_out), 32'd0);
        check({tag, "_alu"}, alu_res_out, 32'd0);
        check({tag, "_md"}, mem_data_out, 32'd0);
        check({tag, "_dest"}, 32'(dest_out), 32'd0);
        check({tag, "_err"}, 32'(mem_err), 32'd0);
        check({tag, "_freeze"}, 32'(freeze), 32'd0);
        check({tag, "_req"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, rd, st;
        logic        r, w, wb;
        int          kind, ack_at;

        rstn = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        drive_idle();
        data_latch = '0; exp_md = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_all_zero("rst");

        // Plain ALU op
        run_instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd7, -1, 32'h0, 1'b0);
        // Load at 1032, ack in third REQ cycle
        run_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 5'd3, 2, 32'hDEADBEEF, 1'b0);
        // Store at 1024, zero-wait ack
        run_instr(1'b0, 1'b0, 1'b1, 32'd1024, 32'h1234, 5'd0, 0, 32'hFFFF_FFFF, 1'b0);
        // Error paths
        run_instr(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 5'd4, 0, 32'h0, 1'b0);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 5'd4, 0, 32'h0, 1'b0);
        run_instr(1'b1, 1'b1, 1'b0, 32'd2048, 32'h0, 5'd4, 0, 32'h0, 1'b0);
        run_instr(1'b1, 1'b1, 1'b1, 32'd1024, 32'h0, 5'd4, 0, 32'h0, 1'b0);
        // Last word in range, then timeout, then normal op
        run_instr(1'b1, 1'b1, 1'b0, 32'd2044, 32'h0, 5'd9, 1, 32'hCAFE0001, 1'b0);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 5'd5, -1, 32'h0, 1'b0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd6, -1, 32'h0, 1'b1);

        // Reset in the middle of a REQ, then a late ack
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        alu_res_in = 32'd1028; dest_in = 5'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(bus_req), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        drive_idle();
        #1;
        check_all_zero("midrst");
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check_all_zero("late_ack");
        data_latch = '0; exp_md = '0;
        run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 5'd2, 1, 32'h600DF00D, 1'b0);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 6));
            wb = 1'(($urandom & 1));
            r = 1'b0; w = 1'b0;
            st = $urandom; rd = $urandom;
            a = BASE + 4 * $urandom_range(0, (1 << BL) - 1);
            case (kind)
                0: a = $urandom;
                1: r = 1'b1;
                2: w = 1'b1;
                3: begin r = 1'b1; a = a + $urandom_range(1, 3); end
                4: begin r = 1'b1; a = $urandom_range(0, BASE - 1); end
                5: begin w = 1'b1; a = BASE + 4 * (1 << BL) + $urandom_range(0, 100000); end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            ack_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            run_instr(wb, r, w, a, st, 5'($urandom), ack_at, rd, 1'($urandom & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
